mux8x1_rr_tdm: RTL and testbench

// - 8-to-1 time-division multiplexer: merges 8 producer channels onto one output stream.
// - Each output beat is tagged with its source channel index (out_sel).
// - Feeds a 1x8 demux at the far end, which routes each beat back to channel y[out_sel].
// - Round-robin arbitration, valid/ready on both sides, one registered output stage.

---
 rtl/mux8x1_rr_tdm.sv | 110 +++++++++++
 tb/tb_mux8x1_rr_tdm.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mux8x1_rr_tdm.sv
// 8-to-1 round-robin TDM multiplexer with a single registered output stage.
// Optional per-channel eligibility mask enabled by defining MUX_CHAN_MASK_EN.
module mux8x1_rr_tdm #(
    parameter int unsigned W    = 8,
    parameter int unsigned CNTW = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [7:0]        i_in_valid,
    input  logic [8*W-1:0]    i_in_data,
    output logic [7:0]        o_in_ready,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [W-1:0]      o_out_data,
    output logic [2:0]        o_out_sel,
    output logic [CNTW-1:0]   o_out_count
`ifdef MUX_CHAN_MASK_EN
    ,
    input  logic [7:0]        i_chan_en
`endif
);

    typedef enum logic {StEmpty, StFull} state_e;

    state_e          r_state;
    logic            r_run;
    logic [2:0]      r_ptr;
    logic            r_valid;
    logic [W-1:0]    r_data;
    logic [2:0]      r_sel;
    logic [CNTW-1:0] r_count;

    logic [7:0]      w_elig;
    logic            w_found;
    logic [2:0]      w_grant_idx;
    logic [2:0]      w_idx;
    logic            w_load;
    logic            w_grant;

`ifdef MUX_CHAN_MASK_EN
    assign w_elig = i_in_valid & i_chan_en;
`else
    assign w_elig = i_in_valid;
`endif

    // First eligible channel scanning upward from r_ptr, wrapping modulo 8.
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = 3'd0;
        w_idx       = 3'd0;
        for (int i = 0; i < 8; i++) begin
            w_idx = r_ptr + 3'(i);
            if (!w_found && w_elig[w_idx]) begin
                w_found     = 1'b1;
                w_grant_idx = w_idx;
            end
        end
    end

    // r_run keeps grants off until the first edge after reset release.
    assign w_load     = (r_state == StEmpty) | i_out_ready;
    assign w_grant    = w_found & w_load & r_run;
    assign o_in_ready = w_grant ? (8'b1 << w_grant_idx) : 8'b0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StEmpty;
            r_run   <= 1'b0;
            r_ptr   <= 3'd0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sel   <= 3'd0;
            r_count <= '0;
        end else begin
            r_run <= 1'b1;
            if (r_valid && i_out_ready) begin
                r_count <= r_count + CNTW'(1);
            end
            if (w_grant) begin
                r_data <= i_in_data[w_grant_idx*W +: W];
                r_sel  <= w_grant_idx;
                r_ptr  <= w_grant_idx + 3'd1;
            end
            case (r_state)
                StEmpty: begin
                    if (w_grant) begin
                        r_state <= StFull;
                        r_valid <= 1'b1;
                    end
                end
                StFull: begin
                    if (i_out_ready && !w_grant) begin
                        r_state <= StEmpty;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= StEmpty;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_out_valid = r_valid;
    assign o_out_data  = r_data;
    assign o_out_sel   = r_sel;
    assign o_out_count = r_count;

endmodule

// File: tb/tb_mux8x1_rr_tdm.sv
// Scoreboard bench for mux8x1_rr_tdm: a queue-based arbitration model predicts grants,
// a separate monitor retires beats and checks data, channel tag, valid and beat count.
module tb_mux8x1_rr_tdm;
    localparam int unsigned W    = 8;
    localparam int unsigned CNTW = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [7:0]        in_valid;
    logic [8*W-1:0]    in_data;
    logic [7:0]        in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      out_data;
    logic [2:0]        out_sel;
    logic [CNTW-1:0]   out_count;
    logic [7:0]        m_en = 8'hFF;
`ifdef MUX_CHAN_MASK_EN
    logic [7:0]        chan_en;
`endif

    mux8x1_rr_tdm #(.W(W), .CNTW(CNTW)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in_valid  (in_valid),
        .i_in_data   (in_data),
        .o_in_ready  (in_ready),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_data  (out_data),
        .o_out_sel   (out_sel),
        .o_out_count (out_count)
`ifdef MUX_CHAN_MASK_EN
        ,
        .i_chan_en   (chan_en)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int m_ptr   = 0;
    int mon_count = 0;
    logic [W+2:0] q[$];   // {channel, data} of beats currently held by the DUT

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, predict the grant, then record it at the edge.
    task automatic cycle(input logic [7:0] v, input logic [8*W-1:0] d, input logic rdy);
        int k;
        logic [7:0] exp;
        logic [7:0] elig;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
`ifdef MUX_CHAN_MASK_EN
        chan_en = m_en;
        elig = v & m_en;
`else
        elig = v;
`endif
        #1;
        k = -1;
        if (q.size() == 0 || rdy) begin
            for (int i = 0; i < 8; i++) begin
                if (k < 0 && elig[(m_ptr + i) % 8]) k = (m_ptr + i) % 8;
            end
        end
        exp = (k >= 0) ? (8'b1 << k) : 8'b0;
        chk("in_ready", {24'b0, in_ready}, {24'b0, exp});
        @(posedge clk);
        if (k >= 0) begin
            q.push_back({k[2:0], d[k*W +: W]});
            m_ptr = (k + 1) % 8;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_in_ready", {24'b0, in_ready}, 32'h0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        q.delete();
        mon_count = 0;
        m_ptr = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release_in_ready", {24'b0, in_ready}, 32'h0);
        @(posedge clk);
    endtask

    // Monitor: retire a beat whenever out_valid & out_ready is seen mid-cycle.
    initial begin
        logic [W+2:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                chk("out_count", {{(32-CNTW){1'b0}}, out_count}, 32'(mon_count));
                chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        chk("unexpected_beat", 32'(out_sel), 32'hFFFF);
                    end else begin
                        e = q.pop_front();
                        chk("out_sel", 32'(out_sel), 32'(e[W+2:W]));
                        chk("out_data", 32'(out_data), 32'(e[W-1:0]));
                    end
                    mon_count = (mon_count + 1) % (1 << CNTW);
                end
            end
        end
    end

    initial begin
        logic [8*W-1:0] d;
        rst_n     = 1'b0;
        in_valid  = 8'hFF;
        in_data   = '0;
        out_ready = 1'b1;
`ifdef MUX_CHAN_MASK_EN
        chan_en = 8'hFF;
`endif
        #3;
        chk("reset_in_ready", {24'b0, in_ready}, 32'h0);
        chk("reset_out_valid", {31'b0, out_valid}, 32'h0);
        chk("reset_out_count", 32'(out_count), 32'h0);
        chk("reset_out_sel", 32'(out_sel), 32'h0);
        chk("reset_out_data", 32'(out_data), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release_in_ready", {24'b0, in_ready}, 32'h0);
        @(posedge clk);

        // Single channel 4 carrying A5.
        d = '0;
        d[4*W +: W] = 8'hA5;
        cycle(8'h10, d, 1'b1);
        cycle(8'h00, d, 1'b1);

        // All channels valid: 0..7,0,1 and nine completed transfers.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(8'hFF, {$urandom, $urandom}, 1'b1);
        end
        #1;
        in_valid  = 8'h00;
        out_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("count_after_10", 32'(out_count), 32'd9);

        // Backpressure with channel 2 held, then channel 3 next.
        do_reset();
        cycle(8'h04, {$urandom, $urandom}, 1'b1);
        for (int i = 0; i < 3; i++) cycle(8'hFF, {$urandom, $urandom}, 1'b0);
        cycle(8'hFF, {$urandom, $urandom}, 1'b1);
        chk("after_bp_sel", 32'(q[q.size()-1][W+2:W]), 32'd3);

        // ptr=6 then channels 0,1 across the wrap.
        cycle(8'h20, {$urandom, $urandom}, 1'b1);
        cycle(8'h03, {$urandom, $urandom}, 1'b1);
        cycle(8'h03, {$urandom, $urandom}, 1'b1);
        cycle(8'h00, {$urandom, $urandom}, 1'b1);

`ifdef MUX_CHAN_MASK_EN
        m_en = 8'hFE;
        for (int i = 0; i < 4; i++) cycle(8'h01, {$urandom, $urandom}, 1'b1);
        m_en = 8'hFF;
`endif

        // Randomized traffic; long enough for the beat counter to wrap several times.
        for (int i = 0; i < 600; i++) begin
            logic [7:0] v;
            v = 8'($urandom) & 8'($urandom | ((i % 3 == 0) ? 32'hFF : 32'h0));
`ifdef MUX_CHAN_MASK_EN
            if ($urandom_range(0, 15) == 0) m_en = 8'($urandom);
`endif
            if ($urandom_range(0, 99) == 0) do_reset();
            cycle(v, {$urandom, $urandom}, $urandom_range(0, 3) != 0);
        end

        cycle(8'h00, '0, 1'b1);
        cycle(8'h00, '0, 1'b1);
        chk("drained", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
